// File: rtl/bram_sp_clr.sv
// Single-port synchronous block RAM with byte-lane write enables, registered read,
// a built-in fill-with-constant clear sequencer and selectable read-during-write mode.
module bram_sp_clr #(
  parameter int unsigned   AW           = 11,
  parameter int unsigned   DW           = 16,
  parameter logic [DW-1:0] CLR_VALUE    = '0,
  parameter bit            CLR_ON_RESET = 1'b1,
  parameter bit            RDW_MODE     = 1'b0,
  parameter bit            OUT_REG      = 1'b0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [AW-1:0]       address,
  input  logic [DW-1:0]       data,
  input  logic [(DW/8)-1:0]   byteena,
  input  logic                wren,
  input  logic                rden,
  input  logic                clear,
  output logic                busy,
  output logic [DW-1:0]       q,
  output logic                qvalid
);

  localparam int unsigned NBE   = DW / 8;
  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [DW-1:0]   mem [DEPTH];

  logic [NBE-1:0]  mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wd;
  logic [DW-1:0]   rd_old;
  logic [DW-1:0]   rd_new;
  logic [DW-1:0]   rd_data;
  logic            rd_fire;

  // Clear sequencer: walks every address once, then hands the array back.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLR_ON_RESET ? S_CLEAR : S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear) begin
            state <= S_CLEAR;
            cnt   <= '0;
          end
        end
        S_CLEAR: begin
          if (&cnt) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy    = (state == S_CLEAR);
  assign rd_fire = !busy && rden;

  // Single write port shared between the clear sequencer and user writes.
  always_comb begin
    mem_be   = '0;
    mem_addr = address;
    mem_wd   = data;
    if (busy) begin
      mem_be   = '1;
      mem_addr = cnt;
      mem_wd   = CLR_VALUE;
    end else if (wren) begin
      mem_be   = byteena;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NBE; i++) begin
      if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wd[8*i +: 8];
    end
  end

  // Write-first view merges enabled lanes of the incoming word over the old one.
  always_comb begin
    rd_old = mem[address];
    rd_new = rd_old;
    for (int i = 0; i < NBE; i++) begin
      if (wren && byteena[i]) rd_new[8*i +: 8] = data[8*i +: 8];
    end
    rd_data = RDW_MODE ? rd_new : rd_old;
  end

  if (OUT_REG) begin : g_out_reg
    logic [DW-1:0] p_data;
    logic          p_valid;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        p_data  <= '0;
        p_valid <= 1'b0;
        q       <= '0;
        qvalid  <= 1'b0;
      end else begin
        p_valid <= rd_fire;
        if (rd_fire) p_data <= rd_data;
        qvalid  <= p_valid;
        if (p_valid) q <= p_data;
      end
    end
  end else begin : g_no_out_reg
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        q      <= '0;
        qvalid <= 1'b0;
      end else begin
        qvalid <= rd_fire;
        if (rd_fire) q <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_bram_sp_clr.sv
// Scoreboard bench for bram_sp_clr: two instances (read-old/latency 1 and
// write-first/latency 2) share one stimulus stream and have independent monitors.
module tb_bram_sp_clr;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam logic [15:0] CLR = 16'hA5A5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data = '0;
  logic [1:0]    byteena = '0;
  logic          wren = 1'b0;
  logic          rden = 1'b0;
  logic          clear = 1'b0;
  logic          busy0, busy1, qvalid0, qvalid1;
  logic [DW-1:0] q0, q1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  bram_sp_clr #(.AW(AW), .DW(DW), .CLR_VALUE(CLR), .CLR_ON_RESET(1'b1),
                .RDW_MODE(1'b0), .OUT_REG(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .address(address), .data(data),
    .byteena(byteena), .wren(wren), .rden(rden), .clear(clear),
    .busy(busy0), .q(q0), .qvalid(qvalid0));

  bram_sp_clr #(.AW(AW), .DW(DW), .CLR_VALUE(CLR), .CLR_ON_RESET(1'b1),
                .RDW_MODE(1'b1), .OUT_REG(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .address(address), .data(data),
    .byteena(byteena), .wren(wren), .rden(rden), .clear(clear),
    .busy(busy1), .q(q1), .qvalid(qvalid1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitors: pop an expectation on every qvalid pulse; check data and arrival cycle.
  always @(posedge clock) begin
    #1;
    if (qvalid0) begin
      if (sb0.size() == 0) chk("dut0_unexpected_qvalid", 32'd1, 32'd0);
      else begin
        e0 = sb0.pop_front();
        chk("dut0_q", 32'(q0), 32'(e0.d));
        chk("dut0_latency", 32'(cyc), 32'(e0.c));
      end
    end
    if (qvalid1) begin
      if (sb1.size() == 0) chk("dut1_unexpected_qvalid", 32'd1, 32'd0);
      else begin
        e1 = sb1.pop_front();
        chk("dut1_q", 32'(q1), 32'(e1.d));
        chk("dut1_latency", 32'(cyc), 32'(e1.c));
      end
    end
  end

  task automatic idle();
    @(negedge clock);
    wren = 1'b0; rden = 1'b0; clear = 1'b0; byteena = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    @(negedge clock);
    address = a; data = d; byteena = be; wren = 1'b1; rden = 1'b0; clear = 1'b0;
  endtask

  // Read (optionally with a same-cycle write); exp0/exp1 are the per-instance results.
  task automatic rd(input logic [3:0] a, input logic [15:0] exp0, input logic [15:0] exp1,
                    input logic do_wr, input logic [15:0] d, input logic [1:0] be);
    exp_t x;
    @(negedge clock);
    address = a; data = d; byteena = be; wren = do_wr; rden = 1'b1; clear = 1'b0;
    x.d = exp0; x.c = cyc + 1; sb0.push_back(x);
    x.d = exp1; x.c = cyc + 2; sb1.push_back(x);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb0.size() + sb1.size()) != 0 && n < 20) begin
      @(posedge clock); #2; n++;
    end
    chk(name, 32'(sb0.size() + sb1.size()), 32'd0);
  endtask

  // Counts cycles each instance spends busy; also flags any qvalid seen meanwhile.
  task automatic wait_clear(input string name);
    int n0 = 0, n1 = 0, n = 0;
    logic qv = 1'b0;
    while ((busy0 || busy1) && n < 100) begin
      if (busy0) n0++;
      if (busy1) n1++;
      @(posedge clock); #1; n++;
      qv = qv | qvalid0 | qvalid1;
    end
    wren = 1'b0; rden = 1'b0;
    chk({name, "_busy_cycles0"}, 32'(n0), 32'd16);
    chk({name, "_busy_cycles1"}, 32'(n1), 32'd16);
    chk({name, "_qvalid_while_busy"}, 32'(qv), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #23;
    chk("rst_q0", 32'(q0), 32'd0);
    chk("rst_q1", 32'(q1), 32'd0);
    chk("rst_qvalid", 32'({qvalid0, qvalid1}), 32'd0);
    chk("rst_busy", 32'({busy0, busy1}), 32'd3);

    // Test 1: automatic clear after reset release, then read every location
    @(negedge clock); reset_n = 1'b1;
    wait_clear("t1");
    for (int a = 0; a < 16; a++) rd(4'(a), CLR, CLR, 1'b0, 16'h0, 2'b00);
    idle(); drain("t1_drain");

    // Test 2: byte-lane writes
    wr(4'd3, 16'h1234, 2'b11);
    wr(4'd3, 16'hAB00, 2'b10);
    rd(4'd3, 16'hAB34, 16'hAB34, 1'b0, 16'h0, 2'b00);
    wr(4'd3, 16'hFFFF, 2'b00);
    rd(4'd3, 16'hAB34, 16'hAB34, 1'b0, 16'h0, 2'b00);
    idle(); drain("t2_drain");

    // Test 3: read during write, old vs merged
    wr(4'd5, 16'h1111, 2'b11);
    rd(4'd5, 16'h1111, 16'h1122, 1'b1, 16'h2222, 2'b01);
    rd(4'd5, 16'h1122, 16'h1122, 1'b0, 16'h0, 2'b00);
    idle(); drain("t3_drain");

    // Test 6: back-to-back reads, then hold
    wr(4'd0, 16'h1000, 2'b11);
    wr(4'd1, 16'h2001, 2'b11);
    wr(4'd2, 16'h3002, 2'b11);
    rd(4'd0, 16'h1000, 16'h1000, 1'b0, 16'h0, 2'b00);
    rd(4'd1, 16'h2001, 16'h2001, 1'b0, 16'h0, 2'b00);
    rd(4'd2, 16'h3002, 16'h3002, 1'b0, 16'h0, 2'b00);
    idle(); drain("t6_drain");
    repeat (3) @(negedge clock);
    chk("t6_hold_q0", 32'(q0), 32'h3002);
    chk("t6_hold_q1", 32'(q1), 32'h3002);
    chk("t6_hold_qvalid", 32'({qvalid0, qvalid1}), 32'd0);

    // Test 4: clear request; writes/reads during busy are ignored
    wr(4'd2, 16'h0F0F, 2'b11);
    idle();
    @(negedge clock); clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    chk("t4_busy_after_req", 32'({busy0, busy1}), 32'd3);
    address = 4'd2; data = 16'hFFFF; byteena = 2'b11; wren = 1'b1; rden = 1'b1;
    wait_clear("t4");
    rd(4'd2, CLR, CLR, 1'b0, 16'h0, 2'b00);
    idle(); drain("t4_drain");
    chk("t4_q_after", 32'(q0), 32'(CLR));

    // Test 5: reset aborts a clear at counter 7; restart clears everything
    wr(4'd10, 16'h5555, 2'b11);
    wr(4'd15, 16'h6666, 2'b11);
    idle();
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    repeat (7) @(posedge clock);
    #1; reset_n = 1'b0;
    #2;
    chk("t5_rst_busy", 32'({busy0, busy1}), 32'd3);
    @(negedge clock); reset_n = 1'b1;
    wait_clear("t5");
    for (int a = 0; a < 16; a++) rd(4'(a), CLR, CLR, 1'b0, 16'h0, 2'b00);
    idle(); drain("t5_drain");

    repeat (4) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
